// File: rtl/switch_allocator_pkg.sv
// Shared router constants and port encoding for the switch allocator.
// Build option: SA_GRANT_CNT_EN adds per-output grant counters.
package switch_allocator_pkg;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input ports, the allocator and the crossbar.
// Build option: SA_GRANT_CNT_EN (counters live on the allocator, not here).
interface switch_allocator_if #(
    parameter int PORT_NUM = switch_allocator_pkg::PORT_NUM,
    parameter int VC_NUM   = switch_allocator_pkg::VC_NUM
);
    import switch_allocator_pkg::*;

    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off;

    logic  [PORT_NUM-1:0]                valid;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel;
    logic  [PORT_NUM-1:0]                xb_valid;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   xb_vc;

    modport master (
        output request, out_port, downstream_vc, on_off,
        input  valid, vc_sel, xb_valid, xb_sel, xb_vc
    );

    modport slave (
        input  request, out_port, downstream_vc, on_off,
        output valid, vc_sel, xb_valid, xb_sel, xb_vc
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer moves past the
// granted slot only when the caller confirms the grant via update_i.
module rr_arbiter #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         update_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] ptr;

    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (update_i && |req_i) begin
            ptr <= (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC round-robin, then
// per-output input round-robin. Build option: SA_GRANT_CNT_EN.
module switch_allocator #(
    parameter int PORT_NUM = switch_allocator_pkg::PORT_NUM,
    parameter int VC_NUM   = switch_allocator_pkg::VC_NUM
) (
    input  logic clk,
    input  logic rst,
    switch_allocator_if.slave bus
`ifdef SA_GRANT_CNT_EN
    ,
    output logic [PORT_NUM-1:0][15:0] grant_cnt_o
`endif
);
    import switch_allocator_pkg::*;

    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]    elig;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]    s1_gnt;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   cv;
    logic  [PORT_NUM-1:0]                cand;
    port_t [PORT_NUM-1:0]                cand_port;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]  s2_req;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]  s2_gnt;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0] w;
    logic  [PORT_NUM-1:0]                out_gnt;
    logic  [PORT_NUM-1:0]                in_won;

    // Out-of-range routes are filtered before on_off is indexed.
    always_comb begin
        elig = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (bus.request[p][v] &&
                    int'(bus.out_port[p][v]) < PORT_NUM) begin
                    elig[p][v] = bus.on_off[bus.out_port[p][v]]
                                           [bus.downstream_vc[p][v]];
                end
            end
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_in
        rr_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk      (clk),
            .rst      (rst),
            .req_i    (elig[p]),
            .update_i (in_won[p]),
            .gnt_o    (s1_gnt[p]),
            .idx_o    (cv[p])
        );
        assign cand[p]      = |s1_gnt[p];
        assign cand_port[p] = bus.out_port[p][cv[p]];
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
        for (genvar p = 0; p < PORT_NUM; p++) begin : g_req
            assign s2_req[o][p] = cand[p] && (int'(cand_port[p]) == o);
        end
        assign out_gnt[o] = |s2_req[o];
        rr_arbiter #(.N(PORT_NUM)) u_port_arb (
            .clk      (clk),
            .rst      (rst),
            .req_i    (s2_req[o]),
            .update_i (out_gnt[o]),
            .gnt_o    (s2_gnt[o]),
            .idx_o    (w[o])
        );
    end

    always_comb begin
        in_won = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            in_won = in_won | s2_gnt[o];
        end
    end

    // rst gates every output so a mid-cycle reset kills grants at once.
    always_comb begin
        bus.valid    = '0;
        bus.vc_sel   = '0;
        bus.xb_valid = '0;
        bus.xb_sel   = '0;
        bus.xb_vc    = '0;
        if (rst) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (in_won[p]) begin
                    bus.valid[p]  = 1'b1;
                    bus.vc_sel[p] = cv[p];
                end
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                if (out_gnt[o]) begin
                    bus.xb_valid[o] = 1'b1;
                    bus.xb_sel[o]   = w[o];
                    bus.xb_vc[o]    = bus.downstream_vc[w[o]][cv[w[o]]];
                end
            end
        end
    end

`ifdef SA_GRANT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_o <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (out_gnt[o] && grant_cnt_o[o] != 16'hFFFF) begin
                    grant_cnt_o[o] <= grant_cnt_o[o] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
